fnd_scan_ctrl: RTL and testbench

FND_SCAN_CTRL -- requirements
Module: fnd_scan_ctrl

---
 rtl/fnd_pkg.sv | 30 +++
 rtl/fnd_scan_ctrl_if.sv | 25 ++
 rtl/bin2bcd_seq.sv | 77 +++++++
 rtl/fnd_scan_ctrl.sv | 125 ++++++++++++
 tb/tb_fnd_scan_ctrl.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fnd_pkg.sv
// Shared constants for the 4-digit seven-segment scan controller:
// segment codes, conversion FSM states and datapath widths.
package fnd_pkg;

  localparam int BIN_W = 14;
  localparam int BCD_W = 16;
  localparam int NDIG  = 4;

  localparam logic [BIN_W-1:0] MAX_DISP = 14'd9999;

  // Active-low segment codes, bit0..6 = a..g, bit7 = dp (always off here).
  localparam logic [9:0][7:0] SEG_DIGITS = {
    8'h90, 8'h80, 8'hF8, 8'h82, 8'h92,
    8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_DASH  = 8'hBF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } conv_state_e;

  function automatic logic [7:0] seg_code(input logic [3:0] d);
    if (d <= 4'd9) return SEG_DIGITS[d];
    return SEG_BLANK;
  endfunction

endpackage

// File: rtl/fnd_scan_ctrl_if.sv
// Host-side signal bundle of the display controller: load handshake,
// display options and the multiplexed segment/common outputs.
interface fnd_scan_ctrl_if;
  import fnd_pkg::*;

  logic             load;
  logic [BIN_W-1:0] value;
  logic [NDIG-1:0]  dp_en;
  logic             lzb_en;
  logic             blink_en;
  logic             busy;
  logic [7:0]       fnd_data;
  logic [NDIG-1:0]  fnd_com;

  modport master (
    output load, value, dp_en, lzb_en, blink_en,
    input  busy, fnd_data, fnd_com
  );

  modport slave (
    input  load, value, dp_en, lzb_en, blink_en,
    output busy, fnd_data, fnd_com
  );

endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary to BCD converter: one bit per cycle,
// BIN_W shift cycles followed by a single done cycle.
module bin2bcd_seq
  import fnd_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [BIN_W-1:0] bin_in,
  output logic             busy,
  output logic             done,
  output logic [BCD_W-1:0] bcd_out
);

  conv_state_e      state_q, state_d;
  logic [BIN_W-1:0] bin_q, bin_d;
  logic [BCD_W-1:0] bcd_q, bcd_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             busy_q;
  logic [BCD_W-1:0] bcd_adj;

  // Add 3 to every nibble that is 5 or more before it is doubled.
  for (genvar gi = 0; gi < NDIG; gi++) begin : g_adj
    assign bcd_adj[4*gi +: 4] = (bcd_q[4*gi +: 4] >= 4'd5) ?
                                bcd_q[4*gi +: 4] + 4'd3 : bcd_q[4*gi +: 4];
  end

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    done    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          bin_d   = bin_in;
          bcd_d   = '0;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        bcd_d = {bcd_adj[BCD_W-2:0], bin_q[BIN_W-1]};
        bin_d = {bin_q[BIN_W-2:0], 1'b0};
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'(BIN_W - 1)) state_d = ST_DONE;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // busy lags the state by one cycle so it covers the SHIFT and DONE cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      busy_q  <= (state_q != ST_IDLE);
    end
  end

  assign busy    = busy_q;
  assign bcd_out = bcd_q;

endmodule

// File: rtl/fnd_scan_ctrl.sv
// Four-digit multiplexed seven-segment driver: converts a loaded binary
// value to BCD, then scans the digits with blanking, decimal points and blink.
module fnd_scan_ctrl
  import fnd_pkg::*;
#(
  parameter int SCAN_DIV  = 100_000,
  parameter int BLINK_DIV = 50_000_000
) (
  input  logic           clk,
  input  logic           reset,
  fnd_scan_ctrl_if.slave bus
);

  localparam int SCAN_W  = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic             conv_start, conv_busy, conv_done;
  logic [BCD_W-1:0] conv_bcd;

  logic [BCD_W-1:0]   digits_q, digits_d;
  logic               ovf_q, ovf_d;
  logic               ovf_pend_q, ovf_pend_d;
  logic [SCAN_W-1:0]  scan_cnt_q, scan_cnt_d;
  logic [1:0]         idx_q, idx_d;
  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic               phase_off_q, phase_off_d;
  logic [7:0]         fnd_data_q, fnd_data_d;
  logic [NDIG-1:0]    fnd_com_q, fnd_com_d;
  logic [7:0]         seg_w [NDIG];

  assign conv_start = bus.load && !conv_busy;

  bin2bcd_seq u_bin2bcd (
    .clk     (clk),
    .reset   (reset),
    .start   (conv_start),
    .bin_in  (bus.value),
    .busy    (conv_busy),
    .done    (conv_done),
    .bcd_out (conv_bcd)
  );

  always_comb begin
    ovf_pend_d = ovf_pend_q;
    digits_d   = digits_q;
    ovf_d      = ovf_q;
    if (conv_start) ovf_pend_d = (bus.value > MAX_DISP);
    // Display registers only move when a conversion has fully completed.
    if (conv_done) begin
      digits_d = conv_bcd;
      ovf_d    = ovf_pend_q;
    end
  end

  always_comb begin
    scan_cnt_d = scan_cnt_q + SCAN_W'(1);
    idx_d      = idx_q;
    if (scan_cnt_q == SCAN_W'(SCAN_DIV - 1)) begin
      scan_cnt_d = '0;
      idx_d      = idx_q + 2'd1;
    end
  end

  always_comb begin
    blink_cnt_d = blink_cnt_q + BLINK_W'(1);
    phase_off_d = phase_off_q;
    if (!bus.blink_en) begin
      blink_cnt_d = '0;
      phase_off_d = 1'b0;
    end else if (blink_cnt_q == BLINK_W'(BLINK_DIV - 1)) begin
      blink_cnt_d = '0;
      phase_off_d = !phase_off_q;
    end
  end

  // Per-digit segment pattern; seg codes carry dp=1, so the mask clears it.
  for (genvar gi = 0; gi < NDIG; gi++) begin : g_seg
    logic       blank;
    logic [7:0] dp_mask;
    if (gi == 0) begin : g_ones
      assign blank = 1'b0;
    end else begin : g_upper
      assign blank = bus.lzb_en && (digits_d[BCD_W-1:4*gi] == '0);
    end
    assign dp_mask   = {~bus.dp_en[gi], 7'h7F};
    assign seg_w[gi] = ovf_d ? SEG_DASH :
                       ((blank ? SEG_BLANK : seg_code(digits_d[4*gi +: 4])) & dp_mask);
  end

  // Outputs are built from next-state values so data and common stay aligned.
  always_comb begin
    fnd_data_d = seg_w[idx_d];
    fnd_com_d  = ~(4'b0001 << idx_d);
    if (bus.blink_en && phase_off_d) fnd_com_d = 4'hF;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      digits_q    <= '0;
      ovf_q       <= 1'b0;
      ovf_pend_q  <= 1'b0;
      scan_cnt_q  <= '0;
      idx_q       <= '0;
      blink_cnt_q <= '0;
      phase_off_q <= 1'b0;
      fnd_data_q  <= SEG_BLANK;
      fnd_com_q   <= '1;
    end else begin
      digits_q    <= digits_d;
      ovf_q       <= ovf_d;
      ovf_pend_q  <= ovf_pend_d;
      scan_cnt_q  <= scan_cnt_d;
      idx_q       <= idx_d;
      blink_cnt_q <= blink_cnt_d;
      phase_off_q <= phase_off_d;
      fnd_data_q  <= fnd_data_d;
      fnd_com_q   <= fnd_com_d;
    end
  end

  assign bus.busy     = conv_busy;
  assign bus.fnd_data = fnd_data_q;
  assign bus.fnd_com  = fnd_com_q;

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// Randomised self-checking bench for fnd_scan_ctrl; expected scan output is
// derived from decimal arithmetic on the displayed value and edge counts.
module tb_fnd_scan_ctrl;
  import fnd_pkg::*;

  localparam int SD = 4;
  localparam int BD = 16;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  // Reference state: edges since reset release, edges with blink enabled,
  // and the value that should currently be on the display.
  int edge_n  = 0;
  int blink_m = 0;
  int disp_val = 0;

  fnd_scan_ctrl_if bus();

  fnd_scan_ctrl #(.SCAN_DIV(SD), .BLINK_DIV(BD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      edge_n  <= 0;
      blink_m <= 0;
    end else begin
      edge_n  <= edge_n + 1;
      blink_m <= bus.blink_en ? blink_m + 1 : 0;
    end
  end

  function automatic logic [7:0] ref_seg(input int d);
    case (d)
      0: return 8'hC0;
      1: return 8'hF9;
      2: return 8'hA4;
      3: return 8'hB0;
      4: return 8'h99;
      5: return 8'h92;
      6: return 8'h82;
      7: return 8'hF8;
      8: return 8'h80;
      9: return 8'h90;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic int pow10(input int i);
    int p;
    p = 1;
    for (int k = 0; k < i; k++) p = p * 10;
    return p;
  endfunction

  function automatic logic [3:0] ref_com();
    int idx;
    logic [3:0] one_hot;
    idx = (edge_n / SD) % 4;
    if (bus.blink_en && ((blink_m / BD) % 2 == 1)) return 4'hF;
    one_hot = 4'b0001 << idx;
    return ~one_hot;
  endfunction

  function automatic logic [7:0] ref_data();
    int idx;
    logic [7:0] s;
    idx = (edge_n / SD) % 4;
    if (disp_val > 9999) return 8'hBF;
    if (bus.lzb_en && idx > 0 && disp_val < pow10(idx)) s = 8'hFF;
    else s = ref_seg((disp_val / pow10(idx)) % 10);
    if (bus.dp_en[idx]) s[7] = 1'b0;
    return s;
  endfunction

  task automatic convert(input int v);
    @(negedge clk);
    bus.value = 14'(v);
    bus.load  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.load = 1'b0;
    repeat (15) @(negedge clk);
    disp_val = v;
    @(negedge clk);
  endtask

  task automatic test_reset();
    bus.load = 1'b0; bus.value = '0; bus.dp_en = '0;
    bus.lzb_en = 1'b0; bus.blink_en = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.fnd_com !== 4'hF || bus.fnd_data !== 8'hFF || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: com=%b data=%h busy=%b expected com=1111 data=ff busy=0",
               bus.fnd_com, bus.fnd_data, bus.busy);
    end
    reset = 1'b1;
    disp_val = 0;
    for (int c = 0; c < 3 * SD; c++) begin
      @(negedge clk);
      checks++;
      if (bus.fnd_com !== ref_com() || bus.fnd_data !== ref_data()) begin
        errors++;
        $display("FAIL post_reset_scan: edge %0d com=%b data=%h expected com=%b data=%h",
                 edge_n, bus.fnd_com, bus.fnd_data, ref_com(), ref_data());
      end
    end
  endtask

  // Load sampled at edge k: busy over edges k+1..k+15, display changes at k+15.
  // A second load (value 42) is offered while busy when ignore_test is set.
  task automatic test_busy_timing(input int v, input bit ignore_test, input string tag);
    @(negedge clk);
    bus.value = 14'(v);
    bus.load  = 1'b1;
    for (int j = 0; j < 18; j++) begin
      @(posedge clk);
      if (j == 15) disp_val = v;
      @(negedge clk);
      if (j == 0 || (ignore_test && j == 6)) bus.load = 1'b0;
      checks++;
      if (bus.busy !== ((j >= 1 && j <= 15) ? 1'b1 : 1'b0)) begin
        errors++;
        $display("FAIL %s_busy: after edge k+%0d busy=%b expected %b",
                 tag, j, bus.busy, (j >= 1 && j <= 15));
      end
      checks++;
      if (bus.fnd_com !== ref_com() || bus.fnd_data !== ref_data()) begin
        errors++;
        $display("FAIL %s_hold: after edge k+%0d com=%b data=%h expected com=%b data=%h",
                 tag, j, bus.fnd_com, bus.fnd_data, ref_com(), ref_data());
      end
      if (ignore_test && j == 5) begin
        bus.value = 14'd42;
        bus.load  = 1'b1;
      end
    end
    for (int c = 0; c < 4 * SD; c++) begin
      @(negedge clk);
      checks++;
      if (bus.fnd_com !== ref_com() || bus.fnd_data !== ref_data()) begin
        errors++;
        $display("FAIL %s_scan: edge %0d com=%b data=%h expected com=%b data=%h",
                 tag, edge_n, bus.fnd_com, bus.fnd_data, ref_com(), ref_data());
      end
    end
  endtask

  task automatic test_lzb();
    bus.dp_en = 4'b0000;
    for (int pass = 0; pass < 2; pass++) begin
      bus.lzb_en = (pass == 0);
      convert(7);
      for (int c = 0; c < 4 * SD; c++) begin
        @(negedge clk);
        checks++;
        if (bus.fnd_com !== ref_com() || bus.fnd_data !== ref_data()) begin
          errors++;
          $display("FAIL lzb%0d_scan: edge %0d com=%b data=%h expected com=%b data=%h",
                   bus.lzb_en, edge_n, bus.fnd_com, bus.fnd_data, ref_com(), ref_data());
        end
      end
    end
  endtask

  task automatic test_overflow();
    int vals [2];
    vals[0] = 10000;
    vals[1] = 16383;
    bus.dp_en  = 4'b1111;
    bus.lzb_en = 1'b1;
    for (int t = 0; t < 2; t++) begin
      convert(vals[t]);
      for (int c = 0; c < 4 * SD; c++) begin
        @(negedge clk);
        checks++;
        if (bus.fnd_data !== 8'hBF || bus.fnd_com !== ref_com()) begin
          errors++;
          $display("FAIL overflow_%0d: com=%b data=%h expected com=%b data=bf",
                   vals[t], bus.fnd_com, bus.fnd_data, ref_com());
        end
      end
    end
  endtask

  task automatic test_random();
    int v;
    for (int t = 0; t < 10; t++) begin
      v = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 99) : $urandom_range(0, 16383);
      bus.dp_en  = 4'($urandom_range(0, 15));
      bus.lzb_en = 1'($urandom_range(0, 1));
      convert(v);
      for (int c = 0; c < 4 * SD; c++) begin
        @(negedge clk);
        checks++;
        if (bus.fnd_com !== ref_com() || bus.fnd_data !== ref_data() || bus.busy !== 1'b0) begin
          errors++;
          $display("FAIL random_%0d: v=%0d dp=%b lzb=%b com=%b data=%h busy=%b expected com=%b data=%h busy=0",
                   t, v, bus.dp_en, bus.lzb_en, bus.fnd_com, bus.fnd_data, bus.busy,
                   ref_com(), ref_data());
        end
      end
    end
  endtask

  task automatic test_blink();
    int off_cycles;
    off_cycles = 0;
    bus.dp_en = 4'b0010;
    bus.lzb_en = 1'b0;
    convert(3141);
    @(negedge clk);
    bus.blink_en = 1'b1;
    for (int c = 0; c < 4 * BD; c++) begin
      @(negedge clk);
      if (bus.fnd_com === 4'hF) off_cycles++;
      checks++;
      if (bus.fnd_com !== ref_com() || bus.fnd_data !== ref_data()) begin
        errors++;
        $display("FAIL blink: blink edge %0d com=%b data=%h expected com=%b data=%h",
                 blink_m, bus.fnd_com, bus.fnd_data, ref_com(), ref_data());
      end
    end
    checks++;
    if (off_cycles != 2 * BD) begin
      errors++;
      $display("FAIL blink_off_count: got %0d dark cycles expected %0d", off_cycles, 2 * BD);
    end
    bus.blink_en = 1'b0;
    for (int c = 0; c < 2 * SD; c++) begin
      @(negedge clk);
      checks++;
      if (bus.fnd_com !== ref_com() || bus.fnd_com === 4'hF) begin
        errors++;
        $display("FAIL blink_disable: com=%b expected %b", bus.fnd_com, ref_com());
      end
    end
  endtask

  task automatic test_reset_during_shift();
    bus.dp_en = 4'b0000;
    bus.lzb_en = 1'b0;
    convert(5678);
    @(negedge clk);
    bus.value = 14'd1234;
    bus.load  = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (bus.fnd_com !== 4'hF || bus.fnd_data !== 8'hFF || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_shift: com=%b data=%h busy=%b expected com=1111 data=ff busy=0",
               bus.fnd_com, bus.fnd_data, bus.busy);
    end
    disp_val = 0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 6 * SD + 8; c++) begin
      @(negedge clk);
      checks++;
      if (bus.fnd_com !== ref_com() || bus.fnd_data !== ref_data() || bus.busy !== 1'b0) begin
        errors++;
        $display("FAIL after_abort: edge %0d com=%b data=%h busy=%b expected com=%b data=%h busy=0",
                 edge_n, bus.fnd_com, bus.fnd_data, bus.busy, ref_com(), ref_data());
      end
    end
  endtask

  initial begin
    test_reset();
    test_busy_timing(1234, 1'b0, "load_1234");
    test_busy_timing(1234, 1'b1, "ignored_42");
    bus.dp_en = 4'b0101;
    test_busy_timing(809, 1'b0, "load_809");
    test_lzb();
    test_overflow();
    test_random();
    test_blink();
    test_reset_during_shift();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
